// File: rtl/conv_pkg.sv
// Shared types and default sizes for the convolution tile loader and its helpers.
package conv_pkg;

  localparam int DATA_W_DFLT = 8;
  localparam int TILE_DFLT   = 4;
  localparam int KER_DFLT    = 3;
  localparam int CNT_W_DFLT  = 16;

  localparam int NPIX = TILE_DFLT * TILE_DFLT;
  localparam int NKER = KER_DFLT * KER_DFLT;

  typedef enum logic [1:0] {
    K_LOAD  = 2'd0,
    P_LOAD  = 2'd1,
    PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/conv_elem_shiftreg.sv
// Indexed-write register file of N elements, exposed as one flat read bus
// with element i at bits [i*DATA_W +: DATA_W].
module conv_elem_shiftreg
  import conv_pkg::*;
#(
  parameter int N      = NKER,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [DATA_W-1:0]   i_data,
  output logic [N*DATA_W-1:0] o_flat
);

  logic [N-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    // NOTE: this storage is reset on purpose: the conv stage must observe all-zero buses after reset.
    if (rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      for (int i = 0; i < N; i++) begin
        if (i_idx == IDX_W'(i)) r_mem[i] <= i_data;
      end
    end
  end

  assign o_flat = r_mem;

endmodule

// File: rtl/conv_tile_loader.sv
// Byte-stream loader that assembles a KERxKER kernel and a TILExTILE pixel tile
// and hands them to the conv stage; the kernel is kept across tiles until reloaded.
module conv_tile_loader
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int TILE   = TILE_DFLT,
  parameter int KER    = KER_DFLT,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          reload_kernel,
  output logic                          tile_valid,
  input  logic                          tile_ready,
  output logic [TILE*TILE*DATA_W-1:0]   tile_pix,
  output logic [KER*KER*DATA_W-1:0]     tile_ker,
  output logic [CNT_W-1:0]              tiles_done,
  output logic                          busy
);

  localparam int N_PIX = TILE * TILE;
  localparam int N_KER = KER * KER;
  localparam int CW    = $clog2(N_PIX);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CNT_W-1:0] r_tiles_done;

  logic w_accept;
  logic w_ker_last;
  logic w_pix_last;
  logic w_handshake;
  logic w_ker_we;
  logic w_pix_we;

  assign in_ready    = (r_state != PRESENT);
  assign tile_valid  = (r_state == PRESENT);
  assign busy        = (r_state == K_LOAD) ? (r_cnt != '0) : 1'b1;
  assign tiles_done  = r_tiles_done;

  assign w_accept    = in_valid && in_ready;
  assign w_ker_we    = w_accept && (r_state == K_LOAD);
  assign w_pix_we    = w_accept && (r_state == P_LOAD);
  assign w_ker_last  = w_ker_we && (r_cnt == CW'(N_KER - 1));
  assign w_pix_last  = w_pix_we && (r_cnt == CW'(N_PIX - 1));
  assign w_handshake = tile_valid && tile_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= K_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns; a missed branch would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      K_LOAD:  if (w_ker_last)  w_state_nxt = P_LOAD;
      P_LOAD:  if (w_pix_last)  w_state_nxt = PRESENT;
      PRESENT: if (w_handshake) w_state_nxt = reload_kernel ? K_LOAD : P_LOAD;
      default: w_state_nxt = K_LOAD;
    endcase
  end

  // The element counter is shared by both load phases and restarts at each phase boundary.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_cnt <= '0;
    end else if (w_ker_last || w_pix_last) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              r_tiles_done <= '0;
    else if (w_handshake) r_tiles_done <= r_tiles_done + 1'b1;
  end

  conv_elem_shiftreg #(
    .N      (N_KER),
    .DATA_W (DATA_W),
    .IDX_W  (CW)
  ) u_ker (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_ker_we),
    .i_idx  (r_cnt),
    .i_data (in_data),
    .o_flat (tile_ker)
  );

  conv_elem_shiftreg #(
    .N      (N_PIX),
    .DATA_W (DATA_W),
    .IDX_W  (CW)
  ) u_pix (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_pix_we),
    .i_idx  (r_cnt),
    .i_data (in_data),
    .o_flat (tile_pix)
  );

endmodule

// File: tb/tb_conv_tile_loader.sv
// Directed bench for conv_tile_loader: handshake timing, kernel retention,
// reload, mid-load reset and a 100-tile gapped stream against a scoreboard.
module tb_conv_tile_loader;
  import conv_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             reload_kernel;
  logic             tile_valid;
  logic             tile_ready;
  logic [127:0]     tile_pix;
  logic [71:0]      tile_ker;
  logic [15:0]      tiles_done;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] exp_pix;
  logic [71:0]  exp_ker;
  logic [7:0]   b;
  logic         need_ker;
  int           acc;

  conv_tile_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .reload_kernel (reload_kernel),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .tile_pix      (tile_pix),
    .tile_ker      (tile_ker),
    .tiles_done    (tiles_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one byte from a negedge and holds it until the loader accepts it.
  task automatic send(input logic [7:0] val);
    logic rdy;
    int   n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = val;
    rdy = in_ready;
    @(posedge clk); #1;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!rdy) chk("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; reload_kernel = 1'b0; tile_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_tile_valid", 128'(tile_valid), 128'(0));
    chk("rst_in_ready",   128'(in_ready),   128'(1));
    chk("rst_busy",       128'(busy),       128'(0));
    chk("rst_tiles_done", 128'(tiles_done), 128'(0));
    chk("rst_pix",        tile_pix,         128'(0));

    // Tile 1: kernel 1..9, pixels 1..16, consumer already ready.
    tile_ready = 1'b1;
    for (int i = 0; i < NKER; i++) begin
      send(8'(i + 1));
      exp_ker[i*8 +: 8] = 8'(i + 1);
      if (i == 0) begin
        @(negedge clk);
        chk("busy_after_first", 128'(busy), 128'(1));
      end
    end
    for (int i = 0; i < NPIX; i++) send(8'(i + 1));
    @(negedge clk);
    chk("t1_tile_valid", 128'(tile_valid),    128'(1));
    chk("t1_ker_lo",     128'(tile_ker[7:0]), 128'(1));
    chk("t1_ker_hi",     128'(tile_ker[71:64]), 128'(9));
    chk("t1_pix_lo",     128'(tile_pix[7:0]), 128'(1));
    chk("t1_pix_hi",     128'(tile_pix[127:120]), 128'(16));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_valid_drop", 128'(tile_valid), 128'(0));
    chk("t1_tiles_done", 128'(tiles_done), 128'(1));

    // Tile 2: stall in PRESENT while a source pushes a byte.
    tile_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      send(8'(8'h20 + i));
      exp_pix[i*8 +: 8] = 8'(8'h20 + i);
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_pix",      tile_pix,       exp_pix);
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_tiles_done", 128'(tiles_done), 128'(2));
    chk("stall_p_load",     128'({in_ready, busy, tile_valid}), 128'(3'b110));
    chk("stall_ker_kept",   128'(tile_ker), 128'(exp_ker));

    // Tile 3: saturated pixels with the retained kernel.
    for (int i = 0; i < NPIX; i++) send(8'hFF);
    @(negedge clk);
    chk("t3_ker_kept", 128'(tile_ker), 128'(exp_ker));
    chk("t3_pix_ff",   tile_pix,       {16{8'hFF}});
    acc = 0;
    for (int r = 0; r < KER_DFLT; r++)
      for (int c = 0; c < KER_DFLT; c++)
        acc += int'(tile_pix[(r*TILE_DFLT + c)*8 +: 8]) * int'(tile_ker[(r*KER_DFLT + c)*8 +: 8]);
    chk("t3_conv_out", 128'(acc & 255), 128'(8'hD3));
    @(posedge clk); #1;

    // Tile 4 handshake with reload, then a new kernel 0x10..0x18.
    reload_kernel = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      send(8'(8'h40 + i));
      exp_pix[i*8 +: 8] = 8'(8'h40 + i);
    end
    @(negedge clk);
    chk("t4_tile_valid", 128'(tile_valid), 128'(1));
    @(posedge clk); #1;
    reload_kernel = 1'b0;
    @(negedge clk);
    chk("reload_k_load",     128'({in_ready, busy, tile_valid}), 128'(3'b100));
    chk("reload_tiles_done", 128'(tiles_done), 128'(4));
    for (int i = 0; i < NKER; i++) begin
      send(8'(8'h10 + i));
      exp_ker[i*8 +: 8] = 8'(8'h10 + i);
    end
    @(negedge clk);
    chk("reload_ker",      128'(tile_ker), 128'(exp_ker));
    chk("reload_pix_kept", tile_pix,       exp_pix);
    chk("reload_p_load",   128'({in_ready, busy, tile_valid}), 128'(3'b110));

    // Partial pixel load, then reset mid-load.
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h60 + i));
      exp_pix[i*8 +: 8] = 8'(8'h60 + i);
    end
    @(negedge clk);
    chk("partial_pix", tile_pix, exp_pix);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pix",        tile_pix,       128'(0));
    chk("midrst_ker",        128'(tile_ker), 128'(0));
    chk("midrst_tiles_done", 128'(tiles_done), 128'(0));
    chk("midrst_k_load",     128'({in_ready, busy, tile_valid}), 128'(3'b100));

    // 100 tiles with random input gaps and periodic kernel reloads.
    tile_ready = 1'b0;
    need_ker   = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (need_ker) begin
        for (int k = 0; k < NKER; k++) begin
          if ($urandom_range(1) == 1) idle($urandom_range(1, 2));
          b = 8'($urandom);
          exp_ker[k*8 +: 8] = b;
          send(b);
        end
      end
      for (int p = 0; p < NPIX; p++) begin
        if ($urandom_range(1) == 1) idle($urandom_range(1, 2));
        b = 8'($urandom);
        exp_pix[p*8 +: 8] = b;
        send(b);
      end
      idle($urandom_range(0, 2));
      @(negedge clk);
      chk("rnd_tile_valid", 128'(tile_valid), 128'(1));
      chk("rnd_pix",        tile_pix,         exp_pix);
      chk("rnd_ker",        128'(tile_ker),   128'(exp_ker));
      need_ker      = (t % 7 == 3);
      reload_kernel = need_ker;
      tile_ready    = 1'b1;
      @(posedge clk); #1;
      tile_ready    = 1'b0;
      reload_kernel = 1'b0;
    end
    @(negedge clk);
    chk("rnd_tiles_done", 128'(tiles_done), 128'(100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
